lfsr_draw_sched: RTL and testbench

//  Shares one 16-bit Fibonacci LFSR (taps 15,13,12,10; shift left, feedback into bit 0)

---
 rtl/lfsr_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/lfsr_draw_sched.sv | 145 ++++++++++++++
 tb/tb_lfsr_draw_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_sched_pkg.sv
// Shared LFSR scheduler types, constants and the single-step LFSR update.
package lfsr_sched_pkg;

   localparam int unsigned LFSR_W = 16;
   localparam logic [LFSR_W-1:0] TAP_MASK = 16'hB400;
   localparam logic [LFSR_W-1:0] SEED_DEFAULT_C = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE,
      ADVANCE,
      RESP
   } state_t;

   // Fibonacci step: shift left, parity of taps 15,13,12,10 enters bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
      return {v[LFSR_W-2:0], ^(v & TAP_MASK)};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_ptr, wrapping at N.
module rr_arbiter #(
   parameter int unsigned N = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_onehot,
   output logic [IW-1:0] o_idx
);

   logic        w_found;
   int unsigned w_j;

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      w_found  = 1'b0;
      w_j      = 0;
      for (int unsigned k = 0; k < N; k++) begin
         w_j = 32'(i_ptr) + k;
         if (w_j >= N) begin
            w_j = w_j - N;
         end
         if (!w_found && i_req[w_j]) begin
            w_found       = 1'b1;
            o_idx         = IW'(w_j);
            o_onehot[w_j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lfsr_draw_sched.sv
// Round-robin scheduler sharing one 16-bit LFSR among NUM_REQ requesters, with seed loading.
// Optional LFSR_ZERO_GUARD_EN: zero seeds load SEED_DEFAULT and raise sticky zero_seed_err.
module lfsr_draw_sched
   import lfsr_sched_pkg::*;
#(
   parameter int unsigned        NUM_REQ        = 4,
   parameter int unsigned        STEPS_PER_DRAW = 16,
   parameter logic [LFSR_W-1:0]  SEED_DEFAULT   = SEED_DEFAULT_C,
   localparam int unsigned       IDW            = $clog2(NUM_REQ)
) (
   input  logic              clk,
   input  logic              nReset,
   input  logic              seed_valid,
   input  logic [LFSR_W-1:0] seed,
   output logic              seed_ready,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic              rnd_valid,
   output logic [LFSR_W-1:0] rnd_data,
   output logic [IDW-1:0]    rnd_id,
`ifdef LFSR_ZERO_GUARD_EN
   output logic              zero_seed_err,
`endif
   output logic              busy
);

   localparam int unsigned CNT_W = (STEPS_PER_DRAW > 1) ? $clog2(STEPS_PER_DRAW) : 1;

   state_t              r_state, w_state_nxt;
   logic [LFSR_W-1:0]   r_lfsr, w_lfsr_nxt, w_step;
   logic [IDW-1:0]      r_ptr, w_ptr_nxt;
   logic [IDW-1:0]      r_win_id, w_win_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
   logic                r_rnd_valid, w_valid_nxt;
   logic [LFSR_W-1:0]   r_rnd_data, w_data_nxt;
   logic [IDW-1:0]      r_rnd_id, w_id_nxt;
   logic [NUM_REQ-1:0]  w_arb_onehot;
   logic [IDW-1:0]      w_arb_idx;
`ifdef LFSR_ZERO_GUARD_EN
   logic                r_zero_err, w_err_nxt;
`endif

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_onehot (w_arb_onehot),
      .o_idx    (w_arb_idx)
   );

   assign w_step = lfsr_step(r_lfsr);

   always_comb begin
      w_state_nxt = r_state;
      w_lfsr_nxt  = r_lfsr;
      w_ptr_nxt   = r_ptr;
      w_win_nxt   = r_win_id;
      w_cnt_nxt   = r_cnt;
      w_gnt_nxt   = '0;
      w_valid_nxt = 1'b0;
      w_data_nxt  = r_rnd_data;
      w_id_nxt    = r_rnd_id;
`ifdef LFSR_ZERO_GUARD_EN
      w_err_nxt   = r_zero_err;
`endif
      unique case (r_state)
         IDLE: begin
            // Seed loading takes priority; pending requests wait a cycle.
            if (seed_valid) begin
               w_lfsr_nxt = seed;
`ifdef LFSR_ZERO_GUARD_EN
               w_err_nxt = (seed == '0);
               if (seed == '0) begin
                  w_lfsr_nxt = SEED_DEFAULT;
               end
`endif
            end else if (|req) begin
               w_gnt_nxt   = w_arb_onehot;
               w_win_nxt   = w_arb_idx;
               w_cnt_nxt   = CNT_W'(STEPS_PER_DRAW - 1);
               w_state_nxt = ADVANCE;
            end
         end
         ADVANCE: begin
            w_lfsr_nxt = w_step;
            if (r_cnt == '0) begin
               w_valid_nxt = 1'b1;
               w_data_nxt  = w_step;
               w_id_nxt    = r_win_id;
               w_state_nxt = RESP;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         RESP: begin
            w_ptr_nxt   = (r_win_id == IDW'(NUM_REQ - 1)) ? '0 : r_win_id + IDW'(1);
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_state     <= IDLE;
         r_lfsr      <= SEED_DEFAULT;
         r_ptr       <= '0;
         r_win_id    <= '0;
         r_cnt       <= '0;
         r_gnt       <= '0;
         r_rnd_valid <= 1'b0;
         r_rnd_data  <= '0;
         r_rnd_id    <= '0;
`ifdef LFSR_ZERO_GUARD_EN
         r_zero_err  <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_lfsr      <= w_lfsr_nxt;
         r_ptr       <= w_ptr_nxt;
         r_win_id    <= w_win_nxt;
         r_cnt       <= w_cnt_nxt;
         r_gnt       <= w_gnt_nxt;
         r_rnd_valid <= w_valid_nxt;
         r_rnd_data  <= w_data_nxt;
         r_rnd_id    <= w_id_nxt;
`ifdef LFSR_ZERO_GUARD_EN
         r_zero_err  <= w_err_nxt;
`endif
      end
   end

   assign seed_ready = (r_state == IDLE);
   assign busy       = (r_state != IDLE);
   assign gnt        = r_gnt;
   assign rnd_valid  = r_rnd_valid;
   assign rnd_data   = r_rnd_data;
   assign rnd_id     = r_rnd_id;
`ifdef LFSR_ZERO_GUARD_EN
   assign zero_seed_err = r_zero_err;
`endif

endmodule

// File: tb/tb_lfsr_draw_sched.sv
// Bench for lfsr_draw_sched: vector table, corner sequences and randomized traffic vs a draw-level
// model. Define LFSR_ZERO_GUARD_EN to exercise the zero-seed guard build.
module tb_lfsr_draw_sched;

   localparam int          N     = 4;
   localparam int          STEPS = 3;
   localparam logic [15:0] SEED_DEF = 16'hACE1;

   logic        clk, nReset, seed_valid, seed_ready, rnd_valid, busy;
   logic [15:0] seed, rnd_data;
   logic [3:0]  req, gnt;
   logic [1:0]  rnd_id;
`ifdef LFSR_ZERO_GUARD_EN
   logic        zero_seed_err;
`endif

   lfsr_draw_sched #(
      .NUM_REQ        (N),
      .STEPS_PER_DRAW (STEPS),
      .SEED_DEFAULT   (SEED_DEF)
   ) dut (
      .clk           (clk),
      .nReset        (nReset),
      .seed_valid    (seed_valid),
      .seed          (seed),
      .seed_ready    (seed_ready),
      .req           (req),
      .gnt           (gnt),
      .rnd_valid     (rnd_valid),
      .rnd_data      (rnd_data),
      .rnd_id        (rnd_id),
`ifdef LFSR_ZERO_GUARD_EN
      .zero_seed_err (zero_seed_err),
`endif
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Draw-level model: a draw takes the whole word STEPS shifts ahead; the unit is busy for
   // STEPS+1 cycles after the grant edge.
   logic [15:0] m_lfsr, m_data;
   logic [3:0]  m_gnt;
   logic        m_valid, m_err;
   int          m_ptr, m_left, m_win, m_id;

   int          cyc_no, g_cyc, v_cyc, n_strobes, cap_id;
   logic [15:0] cap_data;
   int          q_gnt[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] m_next(input logic [15:0] x);
      logic fb;
      fb = x[15] ^ x[13] ^ x[12] ^ x[10];
      return {x[14:0], fb};
   endfunction

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_lfsr = SEED_DEF; m_ptr = 0; m_left = 0; m_win = 0;
      m_gnt = '0; m_valid = 1'b0; m_data = '0; m_id = 0; m_err = 1'b0;
   endtask

   task automatic model_edge(input logic sv, input logic [15:0] sd, input logic [3:0] rq);
      int w;
      m_gnt   = '0;
      m_valid = 1'b0;
      if (m_left == 0) begin
         if (sv) begin
            m_lfsr = sd;
`ifdef LFSR_ZERO_GUARD_EN
            m_err = (sd == 16'h0000);
            if (sd == 16'h0000) m_lfsr = SEED_DEF;
`endif
         end else if (rq != 4'b0000) begin
            w      = pick(rq, m_ptr);
            m_gnt  = 4'(1 << w);
            m_win  = w;
            m_left = STEPS + 1;
         end
      end else begin
         m_left--;
         if (m_left == 1) begin
            for (int s = 0; s < STEPS; s++) m_lfsr = m_next(m_lfsr);
            m_valid = 1'b1;
            m_data  = m_lfsr;
            m_id    = m_win;
            m_ptr   = (m_win + 1) % N;
         end
      end
   endtask

   task automatic check_outputs();
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("rnd_valid", 32'(rnd_valid), 32'(m_valid));
      chk("rnd_data", 32'(rnd_data), 32'(m_data));
      chk("rnd_id", 32'(rnd_id), 32'(m_id));
      chk("seed_ready", 32'(seed_ready), 32'(m_left == 0));
      chk("busy", 32'(busy), 32'(m_left != 0));
`ifdef LFSR_ZERO_GUARD_EN
      chk("zero_seed_err", 32'(zero_seed_err), 32'(m_err));
`endif
      if (gnt != 0 && rnd_valid) chk("gnt_and_valid", 32'(1), 32'(0));
   endtask

   // Called at a negedge: drive inputs, advance the model, compare at the next negedge.
   task automatic cyc(input logic sv, input logic [15:0] sd, input logic [3:0] rq);
      seed_valid = sv;
      seed       = sd;
      req        = rq;
      model_edge(sv, sd, rq);
      @(negedge clk);
      cyc_no++;
      check_outputs();
      if (gnt != 0) begin
         g_cyc = cyc_no;
         for (int i = 0; i < N; i++) if (gnt[i]) q_gnt.push_back(i);
      end
      if (rnd_valid) begin
         v_cyc    = cyc_no;
         n_strobes++;
         cap_data = rnd_data;
         cap_id   = 32'(rnd_id);
      end
   endtask

   task automatic do_reset();
      nReset     = 1'b0;
      seed_valid = 1'b0;
      seed       = '0;
      req        = '0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk);
      @(negedge clk);
      nReset = 1'b1;
   endtask

   task automatic draw(input logic [3:0] rq);
      cyc(1'b0, 16'h0, rq);
      for (int i = 0; i < STEPS + 1; i++) cyc(1'b0, 16'h0, 4'b0000);
   endtask

   typedef struct {
      logic        do_seed;
      logic [15:0] sd;
      logic [3:0]  rq;
      int          exp_id;
      logic [15:0] exp_data;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int s0;
      logic [15:0] rs;
      tbl[0] = '{1'b0, 16'h0000, 4'b0001, 0, 16'h670F};
      tbl[1] = '{1'b1, 16'h8000, 4'b0100, 2, 16'h0004};
      tbl[2] = '{1'b1, 16'h0001, 4'b0010, 1, 16'h0008};
      tbl[3] = '{1'b0, 16'h0000, 4'b1111, 0, 16'h670F};
      tbl[4] = '{1'b0, 16'h0000, 4'b1000, 3, 16'h670F};
      tbl[5] = '{1'b1, 16'h1234, 4'b0110, 1, 16'h91A4};
      cyc_no = 0; n_strobes = 0; g_cyc = -100; v_cyc = -200; cap_id = -1; cap_data = '0;

      @(negedge clk);
      for (int t = 0; t < 6; t++) begin
         do_reset();
         if (tbl[t].do_seed) cyc(1'b1, tbl[t].sd, 4'b0000);
         s0 = n_strobes;
         draw(tbl[t].rq);
         chk($sformatf("tbl%0d_strobes", t), 32'(n_strobes - s0), 32'(1));
         chk($sformatf("tbl%0d_id", t), 32'(cap_id), 32'(tbl[t].exp_id));
         chk($sformatf("tbl%0d_data", t), 32'(cap_data), 32'(tbl[t].exp_data));
         chk($sformatf("tbl%0d_latency", t), 32'(v_cyc - g_cyc), 32'(STEPS));
      end

      // Held requests rotate; then ptr=1 with req 1001 goes to requester 3.
      do_reset();
      q_gnt.delete();
      for (int i = 0; i < 8 * (STEPS + 2); i++) cyc(1'b0, 16'h0, 4'b1111);
      chk("rr_count", 32'(q_gnt.size()), 32'(8));
      for (int i = 0; i < 8; i++) begin
         if (i < q_gnt.size()) chk($sformatf("rr_order%0d", i), 32'(q_gnt[i]), 32'(i % N));
      end
      draw(4'b0001);
      draw(4'b1001);
      chk("rr_ptr1_pick", 32'(cap_id), 32'(3));

      // Seed beats req; seed offered while busy is ignored.
      do_reset();
      cyc(1'b1, 16'h1234, 4'b0010);
      chk("seed_first_no_gnt", 32'(gnt), 32'(0));
      cyc(1'b0, 16'h0, 4'b0010);
      chk("gnt_after_seed", 32'(gnt), 32'(4'b0010));
      for (int i = 0; i < STEPS + 1; i++) cyc(1'b1, 16'hFFFF, 4'b0000);
      chk("busy_seed_ignored", 32'(cap_data), 32'(16'h91A4));

      // Reset mid-draw aborts it; state returns to the default seed and pointer 0.
      do_reset();
      cyc(1'b0, 16'h0, 4'b0010);
      cyc(1'b0, 16'h0, 4'b0000);
      s0 = n_strobes;
      do_reset();
      for (int i = 0; i < 6; i++) cyc(1'b0, 16'h0, 4'b0000);
      chk("abort_no_strobe", 32'(n_strobes - s0), 32'(0));
      draw(4'b0011);
      chk("abort_ptr0", 32'(cap_id), 32'(0));
      chk("abort_seed_def", 32'(cap_data), 32'(16'h670F));

      // Zero seed.
      do_reset();
      cyc(1'b1, 16'h0000, 4'b0000);
      draw(4'b0001);
`ifdef LFSR_ZERO_GUARD_EN
      chk("zero_guard_data", 32'(cap_data), 32'(16'h670F));
      chk("zero_guard_err", 32'(zero_seed_err), 32'(1));
      cyc(1'b1, 16'h8000, 4'b0000);
      chk("zero_guard_clear", 32'(zero_seed_err), 32'(0));
`else
      chk("zero_lock_data", 32'(cap_data), 32'(16'h0000));
      draw(4'b0010);
      chk("zero_lock_data2", 32'(cap_data), 32'(16'h0000));
`endif

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rs = 16'($urandom);
         if ($urandom_range(0, 15) == 0) rs = 16'h0000;
         cyc(($urandom_range(0, 7) == 0), rs, 4'($urandom_range(0, 15)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
